gfx_pixel_cmd_dispatcher: RTL and testbench

- Upstream stage of the graphics render unit.
- Buffers pixel commands from the host in a small FIFO and issues them one at a time over the render unit's strobe interface (pixel fields, coords, render_mode, pixel_write/texture_read).
- Times the strobe hold to match the unit's fixed 4-state pipeline, captures the RGB result on render_ready, and returns it to the host over a valid/ready handshake.
- Guards each transaction with a completion timeout.

---
 rtl/gfx_pixel_cmd_dispatcher.sv | 250 +++++++++++++++++++++++++
 tb/tb_gfx_pixel_cmd_dispatcher.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_pixel_cmd_dispatcher.sv
// Pixel command dispatcher: FIFO-buffered host commands are issued one at a time to the render unit.
// Optional perf counters (perf_done, perf_tmo) are compiled in with GFX_DISP_PERF_EN.
module gfx_pixel_cmd_dispatcher #(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_rgb,
    input  logic [5:0]  cmd_x,
    input  logic [5:0]  cmd_y,
    input  logic [1:0]  cmd_mode,
    input  logic        cmd_op,
    output logic [7:0]  pixel_r,
    output logic [7:0]  pixel_g,
    output logic [7:0]  pixel_b,
    output logic [5:0]  coord_x,
    output logic [5:0]  coord_y,
    output logic [1:0]  render_mode,
    output logic        pixel_write,
    output logic        texture_read,
    input  logic        render_ready,
    input  logic [7:0]  rin_r,
    input  logic [7:0]  rin_g,
    input  logic [7:0]  rin_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [23:0] res_rgb,
    output logic        res_timeout,
`ifdef GFX_DISP_PERF_EN
    output logic [15:0] perf_done,
    output logic [7:0]  perf_tmo,
`endif
    output logic        busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [23:0] rgb;
        logic [5:0]  x;
        logic [5:0]  y;
        logic [1:0]  mode;
        logic        op;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]   rd_ptr_q, rd_ptr_d;
    cmd_t          mem_q [FIFO_DEPTH];
    cmd_t          head;
    logic          full;
    logic          empty;
    logic          push;
    logic          issue;

    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [23:0]   pix_rgb_q, pix_rgb_d;
    logic [5:0]    coord_x_q, coord_x_d;
    logic [5:0]    coord_y_q, coord_y_d;
    logic [1:0]    mode_q, mode_d;
    logic          pixel_write_q, pixel_write_d;
    logic          texture_read_q, texture_read_d;
    logic          res_valid_q, res_valid_d;
    logic [23:0]   res_rgb_q, res_rgb_d;
    logic          res_timeout_q, res_timeout_d;

    // Full when the index bits match but the wrap bits differ.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign push  = cmd_valid && !full;
    assign head  = mem_q[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PW-1:0]] <= '{rgb: cmd_rgb, x: cmd_x, y: cmd_y,
                                         mode: cmd_mode, op: cmd_op};
        end
    end

    always_comb begin
        state_d        = state_q;
        hold_cnt_d     = hold_cnt_q;
        to_cnt_d       = to_cnt_q;
        pix_rgb_d      = pix_rgb_q;
        coord_x_d      = coord_x_q;
        coord_y_d      = coord_y_q;
        mode_d         = mode_q;
        pixel_write_d  = pixel_write_q;
        texture_read_d = texture_read_q;
        res_valid_d    = res_valid_q;
        res_rgb_d      = res_rgb_q;
        res_timeout_d  = res_timeout_q;
        issue          = 1'b0;

        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // A result being consumed this cycle frees the slot for the next issue.
                if (!empty && (!res_valid_q || res_ready)) begin
                    issue          = 1'b1;
                    pix_rgb_d      = head.rgb;
                    coord_x_d      = head.x;
                    coord_y_d      = head.y;
                    mode_d         = head.mode;
                    pixel_write_d  = !head.op;
                    texture_read_d = head.op;
                    hold_cnt_d     = HW'(HOLD_CYCLES - 1);
                    to_cnt_d       = TW'(TIMEOUT - 1);
                    state_d        = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (to_cnt_q != '0) begin
                    to_cnt_d = to_cnt_q - TW'(1);
                end
                if (hold_cnt_q == '0) begin
                    pixel_write_d  = 1'b0;
                    texture_read_d = 1'b0;
                    state_d        = ST_WAIT;
                end else begin
                    hold_cnt_d = hold_cnt_q - HW'(1);
                end
            end
            ST_WAIT: begin
                if (render_ready) begin
                    res_rgb_d     = {rin_r, rin_g, rin_b};
                    res_valid_d   = 1'b1;
                    res_timeout_d = 1'b0;
                    state_d       = ST_IDLE;
                end else if (to_cnt_q == '0) begin
                    res_rgb_d     = '0;
                    res_valid_d   = 1'b1;
                    res_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q - TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wr_ptr_d = push  ? wr_ptr_q + (PW+1)'(1) : wr_ptr_q;
        rd_ptr_d = issue ? rd_ptr_q + (PW+1)'(1) : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            hold_cnt_q     <= '0;
            to_cnt_q       <= '0;
            pix_rgb_q      <= '0;
            coord_x_q      <= '0;
            coord_y_q      <= '0;
            mode_q         <= '0;
            pixel_write_q  <= 1'b0;
            texture_read_q <= 1'b0;
            res_valid_q    <= 1'b0;
            res_rgb_q      <= '0;
            res_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            hold_cnt_q     <= hold_cnt_d;
            to_cnt_q       <= to_cnt_d;
            pix_rgb_q      <= pix_rgb_d;
            coord_x_q      <= coord_x_d;
            coord_y_q      <= coord_y_d;
            mode_q         <= mode_d;
            pixel_write_q  <= pixel_write_d;
            texture_read_q <= texture_read_d;
            res_valid_q    <= res_valid_d;
            res_rgb_q      <= res_rgb_d;
            res_timeout_q  <= res_timeout_d;
        end
    end

`ifdef GFX_DISP_PERF_EN
    logic        done_evt;
    logic        tmo_evt;
    logic [15:0] perf_done_q, perf_done_d;
    logic [7:0]  perf_tmo_q, perf_tmo_d;

    assign done_evt = (state_q == ST_WAIT) && render_ready;
    assign tmo_evt  = (state_q == ST_WAIT) && !render_ready && (to_cnt_q == '0);

    // Saturating: stick at all-ones instead of wrapping.
    always_comb begin
        perf_done_d = perf_done_q;
        perf_tmo_d  = perf_tmo_q;
        if (done_evt && (perf_done_q != 16'hFFFF)) begin
            perf_done_d = perf_done_q + 16'd1;
        end
        if (tmo_evt && (perf_tmo_q != 8'hFF)) begin
            perf_tmo_d = perf_tmo_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_done_q <= '0;
            perf_tmo_q  <= '0;
        end else begin
            perf_done_q <= perf_done_d;
            perf_tmo_q  <= perf_tmo_d;
        end
    end

    assign perf_done = perf_done_q;
    assign perf_tmo  = perf_tmo_q;
`else
    // Without counters the completion and timeout events go unobserved.
`endif

    assign cmd_ready    = !full;
    assign pixel_r      = pix_rgb_q[23:16];
    assign pixel_g      = pix_rgb_q[15:8];
    assign pixel_b      = pix_rgb_q[7:0];
    assign coord_x      = coord_x_q;
    assign coord_y      = coord_y_q;
    assign render_mode  = mode_q;
    assign pixel_write  = pixel_write_q;
    assign texture_read = texture_read_q;
    assign res_valid    = res_valid_q;
    assign res_rgb      = res_rgb_q;
    assign res_timeout  = res_timeout_q;
    assign busy         = (state_q != ST_IDLE) || !empty;

endmodule

// File: tb/tb_gfx_pixel_cmd_dispatcher.sv
// Directed bench for gfx_pixel_cmd_dispatcher; cycle k is the clock period after rising edge k,
// where edge 0 accepts the command and edge 1 issues it.
module tb_gfx_pixel_cmd_dispatcher;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_rgb;
    logic [5:0]  cmd_x;
    logic [5:0]  cmd_y;
    logic [1:0]  cmd_mode;
    logic        cmd_op;
    logic [7:0]  pixel_r, pixel_g, pixel_b;
    logic [5:0]  coord_x, coord_y;
    logic [1:0]  render_mode;
    logic        pixel_write;
    logic        texture_read;
    logic        render_ready;
    logic [7:0]  rin_r, rin_g, rin_b;
    logic        res_valid;
    logic        res_ready;
    logic [23:0] res_rgb;
    logic        res_timeout;
    logic        busy;
`ifdef GFX_DISP_PERF_EN
    logic [15:0] perf_done;
    logic [7:0]  perf_tmo;
`endif

    int tests;
    int fails;
    logic [23:0] exp_q[$];

    gfx_pixel_cmd_dispatcher dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_rgb      (cmd_rgb),
        .cmd_x        (cmd_x),
        .cmd_y        (cmd_y),
        .cmd_mode     (cmd_mode),
        .cmd_op       (cmd_op),
        .pixel_r      (pixel_r),
        .pixel_g      (pixel_g),
        .pixel_b      (pixel_b),
        .coord_x      (coord_x),
        .coord_y      (coord_y),
        .render_mode  (render_mode),
        .pixel_write  (pixel_write),
        .texture_read (texture_read),
        .render_ready (render_ready),
        .rin_r        (rin_r),
        .rin_g        (rin_g),
        .rin_b        (rin_b),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_rgb      (res_rgb),
        .res_timeout  (res_timeout),
`ifdef GFX_DISP_PERF_EN
        .perf_done    (perf_done),
        .perf_tmo     (perf_tmo),
`endif
        .busy         (busy)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: all called at a falling edge.
    task automatic set_cmd(input logic [23:0] rgb, input logic [5:0] x, input logic [5:0] y,
                           input logic [1:0] mode, input logic op);
        cmd_valid = 1'b1;
        cmd_rgb   = rgb;
        cmd_x     = x;
        cmd_y     = y;
        cmd_mode  = mode;
        cmd_op    = op;
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    // Render unit stand-in: wait for a strobe, answer in the first cycle it is low.
    task automatic serve(input logic [23:0] rgb, output logic found, output logic [5:0] x_seen);
        int n;
        n = 0;
        found = 1'b0;
        x_seen = '0;
        while (!(pixel_write || texture_read) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (pixel_write || texture_read) begin
            found = 1'b1;
            x_seen = coord_x;
            n = 0;
            while ((pixel_write || texture_read) && n < 10) begin
                @(negedge clk);
                n++;
            end
            render_ready = 1'b1;
            {rin_r, rin_g, rin_b} = rgb;
            @(negedge clk);
            render_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if ({cmd_ready, pixel_write, texture_read, res_valid, res_timeout, busy} !== 6'b100000) begin
            fails++;
            $display("FAIL reset_ctrl: got %b required 100000", {cmd_ready, pixel_write, texture_read, res_valid, res_timeout, busy});
        end
        tests++;
        if ({res_rgb, pixel_r, pixel_g, pixel_b, coord_x, coord_y, render_mode} !== '0) begin
            fails++;
            $display("FAIL reset_data: got res_rgb=%h coord_x=%h nonzero", res_rgb, coord_x);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        int hi;
        hi = 0;
        @(negedge clk);
        set_cmd(24'h112233, 6'd5, 6'd2, 2'd0, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
        tests++;
        if ({pixel_write, busy} !== 2'b01) begin
            fails++;
            $display("FAIL write_cycle0: got pw,busy=%b required 01", {pixel_write, busy});
        end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c <= 4 && pixel_write === 1'b1 && texture_read === 1'b0) hi++;
            if (c == 1) begin
                tests++;
                if ({pixel_r, pixel_g, pixel_b, coord_x, coord_y, render_mode} !== {24'h112233, 6'd5, 6'd2, 2'd0}) begin
                    fails++;
                    $display("FAIL write_fields: got rgb=%h x=%0d y=%0d mode=%0d required 112233 5 2 0",
                             {pixel_r, pixel_g, pixel_b}, coord_x, coord_y, render_mode);
                end
            end
            if (c == 5) begin
                tests++;
                if ({pixel_write, res_valid} !== 2'b00) begin
                    fails++;
                    $display("FAIL write_strobe_drop: got pw,res_valid=%b required 00", {pixel_write, res_valid});
                end
                render_ready = 1'b1;
                {rin_r, rin_g, rin_b} = 24'hAABBCC;
            end
            if (c == 6) begin
                render_ready = 1'b0;
                tests++;
                if ({res_valid, res_timeout, res_rgb} !== {2'b10, 24'hAABBCC}) begin
                    fails++;
                    $display("FAIL write_result: got v=%b t=%b rgb=%h required v=1 t=0 rgb=aabbcc", res_valid, res_timeout, res_rgb);
                end
            end
        end
        tests++;
        if (hi != 4) begin
            fails++;
            $display("FAIL write_hold: got %0d strobe cycles required 4", hi);
        end
        consume();
        tests++;
        if ({res_valid, pixel_write, busy, coord_x} !== {3'b000, 6'd5}) begin
            fails++;
            $display("FAIL write_after: got v,pw,busy=%b x=%0d required 000 x=5", {res_valid, pixel_write, busy}, coord_x);
        end
    endtask

    task automatic test_texture_read();
        int tr_hi;
        int pw_hi;
        tr_hi = 0;
        pw_hi = 0;
        @(negedge clk);
        set_cmd(24'h445566, 6'd63, 6'd63, 2'd2, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (texture_read === 1'b1) tr_hi++;
            if (pixel_write !== 1'b0) pw_hi++;
            if (c == 1) begin
                tests++;
                if ({coord_x, coord_y, render_mode, pixel_r} !== {6'd63, 6'd63, 2'd2, 8'h44}) begin
                    fails++;
                    $display("FAIL tex_fields: got x=%0d y=%0d mode=%0d r=%h required 63 63 2 44", coord_x, coord_y, render_mode, pixel_r);
                end
            end
            if (c == 5) begin
                render_ready = 1'b1;
                {rin_r, rin_g, rin_b} = 24'h0D0E0F;
            end
            if (c == 6) begin
                render_ready = 1'b0;
                tests++;
                if ({res_valid, res_timeout, res_rgb} !== {2'b10, 24'h0D0E0F}) begin
                    fails++;
                    $display("FAIL tex_result: got v=%b t=%b rgb=%h required v=1 t=0 rgb=0d0e0f", res_valid, res_timeout, res_rgb);
                end
            end
        end
        tests++;
        if (tr_hi != 4 || pw_hi != 0) begin
            fails++;
            $display("FAIL tex_strobes: got tr=%0d pw=%0d cycles required 4 and 0", tr_hi, pw_hi);
        end
        consume();
    endtask

    task automatic test_stale_and_simultaneous();
        int early;
        early = 0;
        @(negedge clk);
        set_cmd(24'h778899, 6'd1, 6'd1, 2'd1, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            if (c == 2) begin
                render_ready = 1'b1;
                {rin_r, rin_g, rin_b} = 24'h123456;
            end
            if (c == 3) render_ready = 1'b0;
            if (c >= 4 && c <= 16 && res_valid !== 1'b0) early++;
            if (c == 16) begin
                render_ready = 1'b1;
                {rin_r, rin_g, rin_b} = 24'h0F0F0F;
            end
            if (c == 17) render_ready = 1'b0;
        end
        tests++;
        if (early != 0) begin
            fails++;
            $display("FAIL stale_ignored: got %0d cycles of early res_valid required 0", early);
        end
        tests++;
        if ({res_valid, res_timeout, res_rgb} !== {2'b10, 24'h0F0F0F}) begin
            fails++;
            $display("FAIL ready_beats_timeout: got v=%b t=%b rgb=%h required v=1 t=0 rgb=0f0f0f", res_valid, res_timeout, res_rgb);
        end
        consume();
    endtask

    task automatic test_timeout();
        int hi;
        hi = 0;
        @(negedge clk);
        set_cmd(24'hFFFFFF, 6'd7, 6'd8, 2'd3, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            if (pixel_write === 1'b1) hi++;
            if (c == 16) begin
                tests++;
                if (res_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL timeout_early: got res_valid=%b at cycle 16 required 0", res_valid);
                end
            end
        end
        tests++;
        if ({res_valid, res_timeout, res_rgb} !== {2'b11, 24'h000000}) begin
            fails++;
            $display("FAIL timeout_result: got v=%b t=%b rgb=%h required v=1 t=1 rgb=000000", res_valid, res_timeout, res_rgb);
        end
        tests++;
        if (hi != 4) begin
            fails++;
            $display("FAIL timeout_hold: got %0d strobe cycles required 4", hi);
        end
        consume();
    endtask

    task automatic test_fifo_backpressure();
        logic [23:0] ret [5];
        logic        found;
        logic [5:0]  xs;
        int          stalled;
        logic [23:0] e;
        for (int i = 0; i < 5; i++) ret[i] = {8'hA0 + 8'(i), 8'h5A, 8'(16 * i)};
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (cmd_ready !== 1'b1) begin
                fails++;
                $display("FAIL fifo_accept%0d: got cmd_ready=%b required 1", i, cmd_ready);
            end
            set_cmd(24'h010101 * 24'(i + 1), 6'(10 + i), 6'd3, 2'd0, 1'b0);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        tests++;
        if ({cmd_ready, busy} !== 2'b01) begin
            fails++;
            $display("FAIL fifo_full: got ready,busy=%b required 01", {cmd_ready, busy});
        end
        serve(ret[0], found, xs);
        exp_q.push_back(ret[0]);
        tests++;
        if (!found || xs !== 6'd10) begin
            fails++;
            $display("FAIL fifo_issue0: got found=%b x=%0d required 1 x=10", found, xs);
        end
        stalled = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (pixel_write !== 1'b0 || res_valid !== 1'b1 || cmd_ready !== 1'b0) stalled++;
        end
        tests++;
        if (stalled != 0) begin
            fails++;
            $display("FAIL fifo_stall: got %0d cycles with issue or lost result required 0", stalled);
        end
        for (int i = 0; i < 5; i++) begin
            e = exp_q.pop_front();
            tests++;
            if (res_valid !== 1'b1 || res_rgb !== e) begin
                fails++;
                $display("FAIL fifo_order%0d: got v=%b rgb=%h required v=1 rgb=%h", i, res_valid, res_rgb, e);
            end
            consume();
            if (i < 4) begin
                serve(ret[i + 1], found, xs);
                exp_q.push_back(ret[i + 1]);
                tests++;
                if (!found || xs !== 6'(11 + i)) begin
                    fails++;
                    $display("FAIL fifo_issue%0d: got found=%b x=%0d required 1 x=%0d", i + 1, found, xs, 11 + i);
                end
            end
        end
        tests++;
        if ({res_valid, busy, cmd_ready} !== 3'b001) begin
            fails++;
            $display("FAIL fifo_drained: got v,busy,ready=%b required 001", {res_valid, busy, cmd_ready});
        end
    endtask

    task automatic test_reset_mid_wait();
        logic       found;
        logic [5:0] xs;
        int         ghost;
        // Reset in WAIT with a second command still queued.
        @(negedge clk);
        set_cmd(24'h202020, 6'd20, 6'd20, 2'd0, 1'b1);
        @(negedge clk);
        set_cmd(24'h212121, 6'd21, 6'd21, 2'd0, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (texture_read !== 1'b1) begin
            fails++;
            $display("FAIL rst_pre_issue: got texture_read=%b required 1", texture_read);
        end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if ({pixel_write, texture_read, res_valid, busy, cmd_ready} !== 5'b00001) begin
            fails++;
            $display("FAIL rst_mid_wait: got pw,tr,v,busy,ready=%b required 00001", {pixel_write, texture_read, res_valid, busy, cmd_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        ghost = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (pixel_write !== 1'b0 || texture_read !== 1'b0 || busy !== 1'b0) ghost++;
        end
        tests++;
        if (ghost != 0) begin
            fails++;
            $display("FAIL rst_fifo_empty: got %0d cycles of activity required 0", ghost);
        end
        // Reset with a pending result and a queued command.
        @(negedge clk);
        set_cmd(24'h303030, 6'd30, 6'd30, 2'd0, 1'b0);
        @(negedge clk);
        set_cmd(24'h313131, 6'd31, 6'd31, 2'd0, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
        serve(24'h333333, found, xs);
        tests++;
        if (!found || res_valid !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL rst_pre_result: got found=%b v=%b busy=%b required 1 1 1", found, res_valid, busy);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({res_valid, busy, cmd_ready, pixel_write} !== 4'b0010) begin
            fails++;
            $display("FAIL rst_result_drop: got v,busy,ready,pw=%b required 0010", {res_valid, busy, cmd_ready, pixel_write});
        end
        @(negedge clk);
        rst = 1'b0;
        ghost = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (pixel_write !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) ghost++;
        end
        tests++;
        if (ghost != 0) begin
            fails++;
            $display("FAIL rst_queue_lost: got %0d cycles of activity required 0", ghost);
        end
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_rgb      = '0;
        cmd_x        = '0;
        cmd_y        = '0;
        cmd_mode     = '0;
        cmd_op       = 1'b0;
        render_ready = 1'b0;
        rin_r        = '0;
        rin_g        = '0;
        rin_b        = '0;
        res_ready    = 1'b0;

        test_reset();
        test_single_write();
        test_texture_read();
        test_stale_and_simultaneous();
        test_timeout();
        test_fifo_backpressure();
        test_reset_mid_wait();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
